// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared constants and the per-entry record for the reorder buffer.
//   ROB_ENTRY_NUM  : number of ROB entries (power of two).
//   INST_TAG_WIDTH : instruction tag width; TAG_INVALID (all-ones) is never a
//                    real entry because ROB_ENTRY_NUM < 2**INST_TAG_WIDTH.
//   COMMON_WIDTH   : result / operand width.
//   REG_IDX_WIDTH  : architectural register index width.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_ENTRY_NUM  = 8;
  localparam int INST_TAG_WIDTH = 4;
  localparam int COMMON_WIDTH   = 32;
  localparam int REG_IDX_WIDTH  = 5;

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                     valid;  // entry allocated
    logic                     ready;  // result written back
    logic [REG_IDX_WIDTH-1:0] dest;   // architectural destination
    logic [COMMON_WIDTH-1:0]  val;    // result value
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_bcast_mux.sv
// -----------------------------------------------------------------------------
// rob_bcast_mux
//   Per-entry broadcast driver. With ROB_WB_BYPASS_EN defined, a writeback
//   hitting this entry in the current cycle is forwarded combinationally onto
//   the broadcast ready/value; otherwise the registered entry state is passed
//   straight through and the writeback inputs are unused.
// Ports:
//   entry_ready/entry_val : registered state of this entry
//   wb_hit                : current writeback targets this (valid) entry
//   wb_val                : current writeback value
//   bcast_ready/bcast_val : broadcast bus slice for this entry
// -----------------------------------------------------------------------------
module rob_bcast_mux #(
  parameter int DATA_W = 32
) (
  input  logic              entry_ready,
  input  logic [DATA_W-1:0] entry_val,
  input  logic              wb_hit,
  input  logic [DATA_W-1:0] wb_val,
  output logic              bcast_ready,
  output logic [DATA_W-1:0] bcast_val
);

`ifdef ROB_WB_BYPASS_EN
  assign bcast_ready = entry_ready | wb_hit;
  assign bcast_val   = wb_hit ? wb_val : entry_val;
`else
  logic unused_wb;
  assign unused_wb   = ^{wb_hit, wb_val};
  assign bcast_ready = entry_ready;
  assign bcast_val   = entry_val;
`endif

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular reorder buffer. Dispatch allocates tags at the tail, execution
//   units write results back by tag, and the head retires in program order,
//   one entry per cycle. Every entry is published on the broadcast bus for the
//   forwarder and reservation stations to snoop.
// Configuration:
//   ROB_WB_BYPASS_EN : forward same-cycle writeback onto bcast_ready/bcast_val.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   flush                 : discard every entry (priority over all else)
//   alloc_req/alloc_dest  : dispatch allocation request
//   alloc_tag, full       : combinational allocation status
//   wb_tag/wb_val         : writeback (wb_tag == TAG_INVALID means none)
//   bcast_*               : producer side of the ROB broadcast bus
//   commit_*              : registered in-order retirement
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRY_NUM,
  parameter int TAG_W   = INST_TAG_WIDTH,
  parameter int DATA_W  = COMMON_WIDTH,
  parameter int REG_W   = REG_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_req,
  input  logic [REG_W-1:0]      alloc_dest,
  output logic [TAG_W-1:0]      alloc_tag,
  output logic                  full,
  input  logic [TAG_W-1:0]      wb_tag,
  input  logic [DATA_W-1:0]     wb_val,
  output logic [ENTRIES-1:0]    bcast_valid,
  output logic [ENTRIES-1:0]    bcast_ready,
  output logic [ENTRIES*TAG_W-1:0]  bcast_tag,
  output logic [ENTRIES*DATA_W-1:0] bcast_val,
  output logic                  commit_valid,
  output logic [REG_W-1:0]      commit_dest,
  output logic [TAG_W-1:0]      commit_tag,
  output logic [DATA_W-1:0]     commit_val
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [TAG_W-1:0] TAG_NONE    = '1;
  localparam logic [TAG_W-1:0] ENTRIES_TAG = TAG_W'(ENTRIES);
  localparam logic [IDX_W:0]   COUNT_FULL  = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W:0]   COUNT_ONE   = (IDX_W+1)'(1);

  rob_entry_t        rob_q [ENTRIES];
  rob_entry_t        rob_d [ENTRIES];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              commit_valid_q, commit_valid_d;
  logic [REG_W-1:0]  commit_dest_q, commit_dest_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic [DATA_W-1:0] commit_val_q, commit_val_d;

  logic              alloc_en, commit_en, wb_en;
  logic [IDX_W-1:0]  wb_idx;
  logic [ENTRIES-1:0] wb_hit;

  // Full and empty are told apart by count, never by head == tail.
  assign full      = (count_q == COUNT_FULL);
  assign alloc_tag = full ? TAG_NONE : TAG_W'(tail_q);
  assign alloc_en  = alloc_req && !full;
  assign commit_en = rob_q[head_q].valid && rob_q[head_q].ready;
  assign wb_idx    = wb_tag[IDX_W-1:0];
  assign wb_en     = (wb_tag != TAG_NONE) && (wb_tag < ENTRIES_TAG) && rob_q[wb_idx].valid;

  always_comb begin
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_dest_d  = commit_dest_q;
    commit_tag_d   = commit_tag_q;
    commit_val_d   = commit_val_q;

    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        rob_d[i].valid = 1'b0;
        rob_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wb_en) begin
        rob_d[wb_idx].ready = 1'b1;
        rob_d[wb_idx].val   = wb_val;
      end
      // Commit looks only at pre-edge state, so a writeback to the head this
      // cycle retires on the next edge; the clear below overrides it.
      if (commit_en) begin
        commit_valid_d        = 1'b1;
        commit_dest_d         = rob_q[head_q].dest;
        commit_tag_d          = TAG_W'(head_q);
        commit_val_d          = rob_q[head_q].val;
        rob_d[head_q].valid   = 1'b0;
        rob_d[head_q].ready   = 1'b0;
        head_d                = head_q + 1'b1;
      end
      // Tail can only equal head when empty (no commit) or full (no alloc).
      if (alloc_en) begin
        rob_d[tail_q].valid = 1'b1;
        rob_d[tail_q].ready = 1'b0;
        rob_d[tail_q].dest  = alloc_dest;
        tail_d              = tail_q + 1'b1;
      end
      case ({alloc_en, commit_en})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry array is reset because its values are visible on
  // bcast_val straight out of reset; a storage-only array would skip this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) rob_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_tag_q   <= '0;
      commit_val_q   <= '0;
    end else begin
      rob_q          <= rob_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_tag_q   <= commit_tag_d;
      commit_val_q   <= commit_val_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_tag   = commit_tag_q;
  assign commit_val   = commit_val_q;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_bcast
    assign wb_hit[i]                     = wb_en && (wb_idx == IDX_W'(i));
    assign bcast_valid[i]                = rob_q[i].valid;
    assign bcast_tag[i*TAG_W +: TAG_W]   = TAG_W'(i);

    rob_bcast_mux #(.DATA_W(DATA_W)) u_mux (
      .entry_ready (rob_q[i].ready),
      .entry_val   (rob_q[i].val),
      .wb_hit      (wb_hit[i]),
      .wb_val      (wb_val),
      .bcast_ready (bcast_ready[i]),
      .bcast_val   (bcast_val[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed bench for reorder_buffer: reset, fill, out-of-order writeback,
//   pointer wrap, flush and broadcast bypass. Inputs change 1 time unit after
//   the rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int ENTRIES = 8;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam logic [TAG_W-1:0] TAG_INV = 4'hF;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      alloc_req;
  logic [REG_W-1:0]          alloc_dest;
  logic [TAG_W-1:0]          alloc_tag;
  logic                      full;
  logic [TAG_W-1:0]          wb_tag;
  logic [DATA_W-1:0]         wb_val;
  logic [ENTRIES-1:0]        bcast_valid;
  logic [ENTRIES-1:0]        bcast_ready;
  logic [ENTRIES*TAG_W-1:0]  bcast_tag;
  logic [ENTRIES*DATA_W-1:0] bcast_val;
  logic                      commit_valid;
  logic [REG_W-1:0]          commit_dest;
  logic [TAG_W-1:0]          commit_tag;
  logic [DATA_W-1:0]         commit_val;

  int errors = 0;
  int checks = 0;

  reorder_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_dest   (alloc_dest),
    .alloc_tag    (alloc_tag),
    .full         (full),
    .wb_tag       (wb_tag),
    .wb_val       (wb_val),
    .bcast_valid  (bcast_valid),
    .bcast_ready  (bcast_ready),
    .bcast_tag    (bcast_tag),
    .bcast_val    (bcast_val),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_tag   (commit_tag),
    .commit_val   (commit_val)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    alloc_req  = 1'b0;
    alloc_dest = '0;
    wb_tag     = TAG_INV;
    wb_val     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
  endtask

  task automatic alloc_n(input int n, input int dest_base);
    for (int k = 0; k < n; k++) begin
      alloc_req  = 1'b1;
      alloc_dest = REG_W'(dest_base + k);
      step();
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++; if (bcast_valid !== '0) begin errors++; $display("FAIL reset_bvalid: got %0h want 0", bcast_valid); end
    checks++; if (bcast_ready !== '0) begin errors++; $display("FAIL reset_bready: got %0h want 0", bcast_ready); end
    checks++; if (bcast_val !== '0) begin errors++; $display("FAIL reset_bval: got %0h want 0", bcast_val); end
    checks++; if ({commit_valid, commit_dest, commit_tag, commit_val} !== '0) begin
      errors++; $display("FAIL reset_commit: got v=%0b d=%0h t=%0h val=%0h want all 0", commit_valid, commit_dest, commit_tag, commit_val);
    end
    checks++; if (full !== 1'b0 || alloc_tag !== 4'h0) begin
      errors++; $display("FAIL reset_alloc: got full=%0b tag=%0h want 0/0", full, alloc_tag);
    end
    rst = 1'b1;
    step();
    for (int i = 0; i < ENTRIES; i++) begin
      checks++; if (bcast_tag[i*TAG_W +: TAG_W] !== TAG_W'(i)) begin
        errors++; $display("FAIL bcast_tag_%0d: got %0h want %0h", i, bcast_tag[i*TAG_W +: TAG_W], i);
      end
    end
    // Mid-stream reset with 3 live entries and a commit in flight.
    alloc_n(3, 1);
    wb_tag = 4'd0; wb_val = 32'h77;
    step();
    wb_tag = TAG_INV;
    step();
    checks++; if (commit_valid !== 1'b1 || bcast_valid !== 8'b0000_0110) begin
      errors++; $display("FAIL pre_reset: got cv=%0b bv=%0h want 1/06", commit_valid, bcast_valid);
    end
    rst = 1'b0;
    #1;
    checks++; if (bcast_valid !== '0 || commit_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got bv=%0h cv=%0b want 0/0", bcast_valid, commit_valid);
    end
    checks++; if (full !== 1'b0 || alloc_tag !== 4'h0) begin
      errors++; $display("FAIL async_reset_ptr: got full=%0b tag=%0h want 0/0", full, alloc_tag);
    end
    #1;
    rst = 1'b1;
    alloc_req = 1'b1; alloc_dest = 5'd4;
    checks++; if (alloc_tag !== 4'h0) begin errors++; $display("FAIL post_reset_tag: got %0h want 0", alloc_tag); end
    step();
    alloc_req = 1'b0;
    checks++; if (bcast_valid !== 8'h01) begin errors++; $display("FAIL post_reset_alloc: got %0h want 01", bcast_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < ENTRIES; k++) begin
      alloc_req = 1'b1; alloc_dest = REG_W'(k);
      checks++; if (alloc_tag !== TAG_W'(k)) begin errors++; $display("FAIL fill_tag_%0d: got %0h want %0h", k, alloc_tag, k); end
      step();
    end
    checks++; if (full !== 1'b1 || alloc_tag !== TAG_INV) begin
      errors++; $display("FAIL fill_full: got full=%0b tag=%0h want 1/f", full, alloc_tag);
    end
    step();  // 9th request, must be dropped
    alloc_req = 1'b0;
    checks++; if (full !== 1'b1 || bcast_valid !== 8'hFF || bcast_ready !== 8'h00) begin
      errors++; $display("FAIL fill_drop: got full=%0b bv=%0h br=%0h want 1/ff/00", full, bcast_valid, bcast_ready);
    end
  endtask

  task automatic test_ooo_writeback();
    do_reset();
    alloc_n(3, 5);
    wb_tag = 4'd2; wb_val = 32'h33;
    step();
    checks++; if (commit_valid !== 1'b0 || bcast_ready !== 8'b100) begin
      errors++; $display("FAIL ooo_wb2: got cv=%0b br=%0h want 0/04", commit_valid, bcast_ready);
    end
    wb_tag = 4'd0; wb_val = 32'h11;
    step();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_same_edge: got cv=%0b want 0", commit_valid); end
    wb_tag = 4'd1; wb_val = 32'h22;
    step();
    wb_tag = TAG_INV;
    checks++; if ({commit_valid, commit_tag, commit_dest, commit_val} !== {1'b1, 4'd0, 5'd5, 32'h11}) begin
      errors++; $display("FAIL ooo_c0: got v=%0b t=%0h d=%0h val=%0h want 1/0/5/11", commit_valid, commit_tag, commit_dest, commit_val);
    end
    step();
    checks++; if ({commit_valid, commit_tag, commit_dest, commit_val} !== {1'b1, 4'd1, 5'd6, 32'h22}) begin
      errors++; $display("FAIL ooo_c1: got v=%0b t=%0h d=%0h val=%0h want 1/1/6/22", commit_valid, commit_tag, commit_dest, commit_val);
    end
    step();
    checks++; if ({commit_valid, commit_tag, commit_dest, commit_val} !== {1'b1, 4'd2, 5'd7, 32'h33}) begin
      errors++; $display("FAIL ooo_c2: got v=%0b t=%0h d=%0h val=%0h want 1/2/7/33", commit_valid, commit_tag, commit_dest, commit_val);
    end
    step();
    checks++; if (commit_valid !== 1'b0 || commit_val !== 32'h33 || bcast_valid !== '0) begin
      errors++; $display("FAIL ooo_idle: got cv=%0b val=%0h bv=%0h want 0/33/00", commit_valid, commit_val, bcast_valid);
    end
  endtask

  task automatic test_wrap();
    logic [TAG_W-1:0]  rec_tag  [10];
    logic [REG_W-1:0]  rec_dest [10];
    logic [DATA_W-1:0] rec_val  [10];
    int n = 0;
    int t;
    do_reset();
    alloc_n(ENTRIES, 0);
    wb_tag = 4'd0; wb_val = 32'h100;
    step();
    wb_tag = TAG_INV;
    alloc_req = 1'b1; alloc_dest = 5'd8;
    checks++; if (full !== 1'b1 || alloc_tag !== TAG_INV) begin
      errors++; $display("FAIL wrap_gate: got full=%0b tag=%0h want 1/f", full, alloc_tag);
    end
    step();  // entry 0 retires, alloc blocked by pre-edge full
    checks++; if ({commit_valid, commit_tag, commit_val, full} !== {1'b1, 4'd0, 32'h100, 1'b0}) begin
      errors++; $display("FAIL wrap_c0: got v=%0b t=%0h val=%0h full=%0b want 1/0/100/0", commit_valid, commit_tag, commit_val, full);
    end
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL wrap_tag0: got %0h want 0", alloc_tag); end
    wb_tag = 4'd1; wb_val = 32'h101;
    step();  // 9th instruction takes tag 0
    wb_tag = TAG_INV; alloc_dest = 5'd9;
    step();  // entry 1 retires, alloc blocked again
    checks++; if (commit_tag !== 4'd1 || alloc_tag !== 4'd1) begin
      errors++; $display("FAIL wrap_c1: got ct=%0h at=%0h want 1/1", commit_tag, alloc_tag);
    end
    step();  // 10th instruction takes tag 1
    alloc_req = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin wb_tag = TAG_W'((j + 2) % 8); wb_val = 32'h300 + 32'((j + 2) % 8); end
      else wb_tag = TAG_INV;
      step();
      if (commit_valid === 1'b1 && n < 10) begin
        rec_tag[n] = commit_tag; rec_dest[n] = commit_dest; rec_val[n] = commit_val; n++;
      end
    end
    wb_tag = TAG_INV;
    checks++; if (n !== 8) begin errors++; $display("FAIL wrap_count: got %0d want 8", n); end
    for (int k = 0; k < n && k < 8; k++) begin
      t = (k + 2) % 8;
      checks++; if ({rec_tag[k], rec_dest[k], rec_val[k]} !== {TAG_W'(t), REG_W'(t < 2 ? t + 8 : t), 32'h300 + 32'(t)}) begin
        errors++; $display("FAIL wrap_c%0d: got t=%0h d=%0h val=%0h want %0h/%0h/%0h", k, rec_tag[k], rec_dest[k], rec_val[k],
                           t, (t < 2 ? t + 8 : t), 32'h300 + t);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(5, 0);
    wb_tag = 4'd0; wb_val = 32'h11;
    step();  // head now ready: would commit next edge
    flush = 1'b1; alloc_req = 1'b1; wb_tag = 4'd2; wb_val = 32'h55;
    step();
    idle_inputs();
    checks++; if ({commit_valid, bcast_valid, bcast_ready} !== '0) begin
      errors++; $display("FAIL flush_state: got cv=%0b bv=%0h br=%0h want 0/00/00", commit_valid, bcast_valid, bcast_ready);
    end
    step();
    checks++; if (commit_valid !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_idle: got cv=%0b full=%0b want 0/0", commit_valid, full);
    end
    alloc_req = 1'b1;
    checks++; if (alloc_tag !== 4'd0) begin errors++; $display("FAIL flush_tag: got %0h want 0", alloc_tag); end
    step();
    alloc_req = 1'b0;
    checks++; if (bcast_valid !== 8'h01 || bcast_ready !== 8'h00) begin
      errors++; $display("FAIL flush_alloc: got bv=%0h br=%0h want 01/00", bcast_valid, bcast_ready);
    end
  endtask

  task automatic test_bypass();
    logic              exp_rdy;
    logic [DATA_W-1:0] exp_val;
`ifdef ROB_WB_BYPASS_EN
    exp_rdy = 1'b1; exp_val = 32'hABCD;
`else
    exp_rdy = 1'b0; exp_val = 32'h0;
`endif
    do_reset();
    alloc_n(4, 0);
    wb_tag = 4'd3; wb_val = 32'hABCD;
    #1;
    checks++; if (bcast_ready[3] !== exp_rdy || bcast_val[3*DATA_W +: DATA_W] !== exp_val) begin
      errors++; $display("FAIL bypass_same: got r=%0b v=%0h want %0b/%0h", bcast_ready[3], bcast_val[3*DATA_W +: DATA_W], exp_rdy, exp_val);
    end
    step();
    checks++; if (bcast_ready !== 8'b1000 || bcast_val[3*DATA_W +: DATA_W] !== 32'hABCD) begin
      errors++; $display("FAIL bypass_after: got br=%0h v=%0h want 08/abcd", bcast_ready, bcast_val[3*DATA_W +: DATA_W]);
    end
    // Writebacks to an unallocated entry or an out-of-range tag are ignored.
    wb_tag = 4'd4; wb_val = 32'h44;
    #1;
    checks++; if (bcast_ready[4] !== 1'b0) begin errors++; $display("FAIL bypass_invalid: got %0b want 0", bcast_ready[4]); end
    step();
    wb_tag = 4'd9; wb_val = 32'h99;
    step();
    wb_tag = TAG_INV;
    checks++; if (bcast_ready !== 8'b1000 || bcast_val[4*DATA_W +: DATA_W] !== 32'h0) begin
      errors++; $display("FAIL wb_ignored: got br=%0h v4=%0h want 08/0", bcast_ready, bcast_val[4*DATA_W +: DATA_W]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_writeback();
    test_wrap();
    test_flush();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- Circular reorder buffer that allocates instruction tags at issue and accepts execution results by tag.
- Retires results in program order, one per cycle.
- Drives the ROB broadcast bus (`valid`/`ready`/`tag`/`val` per entry) that the forwarder and reservation stations snoop to resolve pending operands.
- Sits between dispatch (allocation), execution units (writeback) and the register file (commit).

## Interface

Parameters:
- `ENTRIES`, 8: number of entries; must equal `ROB_ENTRY_NUM`; power of two.
- `TAG_W`, 4: tag width (`INST_TAG_WIDTH`); `TAG_INVALID` is all-ones, and `ENTRIES` must be less than `2**TAG_W`.
- `DATA_W`, 32: result width (`COMMON_WIDTH`).
- `REG_W`, 5: architectural destination register index width.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `flush`  input  1  discard all entries (mispredict/exception).
- `alloc_req`  input  1  dispatch requests one entry.
- `alloc_dest`  input  REG_W  destination register of the allocating instruction.
- `alloc_tag`  output  TAG_W  combinational; tail index when `!full`, else `TAG_INVALID`.
- `full`  output  1  combinational; count == ENTRIES.
- `wb_tag`  input  TAG_W  writeback tag; `TAG_INVALID` = no writeback.
- `wb_val`  input  DATA_W  writeback value.
- `bcast_valid`  output  ENTRIES  entry i allocated.
- `bcast_ready`  output  ENTRIES  entry i result present.
- `bcast_tag`  output  ENTRIES*TAG_W  tag of entry i (= i), slice i.
- `bcast_val`  output  ENTRIES*DATA_W  value of entry i, slice i.
- `commit_valid`  output  1  registered; one retirement this cycle.
- `commit_dest`, `commit_tag`, `commit_val`  output  REG_W/TAG_W/DATA_W  retired entry fields.

The `bcast_*` group is the producer side of `rob_broadcast_inf`.

## Operation

State: per-entry `valid`, `ready`, `dest`, `val`. Also `head`, `tail` (log2(ENTRIES) bits, wrap modulo ENTRIES) and `count` (log2(ENTRIES)+1 bits).

Per rising edge, priority is flush > {alloc, writeback, commit}.

- **Flush:**
  - Clear all `valid` and `ready`.
  - Set `head = tail = count = 0` and `commit_valid = 0`.
  - Ignore same-cycle alloc, writeback and commit.
- **Allocate** (`alloc_req && !full`):
  - Set entry[tail] `valid=1`, `ready=0`, `dest=alloc_dest`.
  - Advance `tail` by 1.
  - When `full`, `alloc_req` is dropped silently; dispatch must hold it.
- **Writeback** (`wb_tag != TAG_INVALID`, `wb_tag < ENTRIES`, entry valid):
  - Set `ready=1` and `val=wb_val`.
  - Writeback to an invalid entry or an out-of-range tag is ignored.
  - A repeat writeback to a ready entry overwrites `val`.
- **Commit** (entry[head] valid && ready, as state stood before this edge):
  - Register `commit_valid=1`, `commit_dest`, `commit_tag=head`, `commit_val`.
  - Clear entry[head] `valid` and `ready`; advance `head`.
  - Otherwise `commit_valid=0`; the other commit fields hold their previous values.
- **Count:** `count` updates by +alloc −commit. Simultaneous alloc and commit leaves it unchanged.
- **Full gating:** `full` is evaluated before the edge. A commit in the same cycle does not admit an alloc when full.
- **Writeback and commit on the head together:** a writeback to the head entry commits on the following edge, not the same one.
- **Broadcast:** `bcast_tag` slice i is constant i. `bcast_valid`, `bcast_ready` and `bcast_val` are registered state (see Configuration).

## Timing

- **Reset values:**
  - `bcast_valid`/`bcast_ready` = 0 and `bcast_val` = 0.
  - `commit_valid` = 0, `commit_*` = 0.
  - `full` = 0, `alloc_tag` = 0.
  - `head`/`tail`/`count` = 0.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.
- **Alloc latency:** `alloc_tag` is valid in the request cycle; the entry appears on `bcast_valid` after that edge.
- **Writeback-to-commit:** a writeback at edge N makes the entry ready after N. If the entry is at head, `commit_valid` is high after edge N+1.
- **Throughput:** one alloc, one writeback and one commit per cycle.
- **Pointer wrap:** `tail`/`head` go from ENTRIES-1 to 0. Full and empty are distinguished by `count`, never by pointer equality.

## Configuration

- `ROB_WB_BYPASS_EN` defined:
  - `bcast_ready[i]`/`bcast_val[i]` are combinationally ORed/muxed with the current-cycle writeback when `wb_tag==i` and the entry is valid.
  - Snoopers sampling at the falling edge see a result in its writeback cycle.
- Not defined: broadcast is pure registered state; results are visible one edge later.
- Commit timing is identical in both builds.

## Structure

- Shared package/header holds `TAG_INVALID`, `ROB_ENTRY_NUM` and `INST_TAG_WIDTH`.
- Package also holds the `rob_entry` typedef (`valid`, `ready`, `dest`, `val`).
- One sub-module is natural: `rob_bcast_mux`, the per-entry bypass mux; it is compiled as a wire-through without `ROB_WB_BYPASS_EN`.

## Test plan

- **Reset:** drop `rst` mid-stream with 3 entries live → all `bcast_valid`=0, `commit_valid`=0, `count`=0 at once; first alloc after release gets tag 0.
- **Fill:** 8 allocs, no writeback → tags 0..7 in order, `full`=1. A 9th `alloc_req` is dropped; `alloc_tag`=`TAG_INVALID`.
- **Out-of-order writeback:** alloc tags 0,1,2, then writeback tag 2=0x33, tag 0=0x11, tag 1=0x22. Required: commits in order 0x11, 0x22, 0x33, with 0x11 committing the edge after its writeback.
- **Wrap:** alloc/commit 10 instructions through a full buffer. The 9th instruction gets tag 0 after entry 0 retires, and its commit carries `commit_tag`=0.
- **Flush:** flush with 5 live entries and a simultaneous writeback/alloc → zero entries afterwards and no commit. The next alloc gets tag 0.
- **Bypass:** writeback tag 3=0xABCD while entry 3 is valid. With `ROB_WB_BYPASS_EN`, `bcast_ready[3]`=1 in that cycle; without it, only after the edge.
